// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, req/ack imem port,
// decode redirects and a one-entry skid buffer for responses arriving under stall.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        jump,
    input  logic [25:0] jAddr,
    input  logic [31:0] id_next_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] next_addr,
    output logic [31:0] instr,
    output logic        instr_valid
);

    localparam int unsigned XW = 32;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] pc_q, pc_d;
    logic [XW-1:0] redir_pc_q, redir_pc_d;
    logic          skid_valid_q, skid_valid_d;
    logic [XW-1:0] skid_instr_q, skid_instr_d;
    logic [XW-1:0] skid_addr_q, skid_addr_d;
    logic [XW-1:0] next_addr_q, next_addr_d;
    logic [XW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;

    logic          redirect;
    logic [XW-1:0] target;
    logic          ack_fire;
    logic          good_rsp;
    logic [XW-1:0] pc_plus4;
    logic          unused_id_bits;

    assign unused_id_bits = ^id_next_addr[27:0];

    assign imem_req    = !rst && !skid_valid_q;
    assign imem_addr   = pc_q;
    assign next_addr   = next_addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

    assign redirect = (branch_taken || jump) && !stall;
    assign target   = jump ? {id_next_addr[31:28], jAddr, 2'b00} : branch_addr;
    assign ack_fire = imem_req && imem_ack;
    assign good_rsp = (state_q == FETCH) && ack_fire && !redirect;
    assign pc_plus4 = pc_q + XW'(4);

    // Next-state for PC / redirect FSM, skid buffer and IF/ID register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        next_addr_d  = next_addr_q;
        instr_d      = instr_q;
        valid_d      = valid_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    // A request still waiting for its ack must keep its address.
                    if (imem_req && !imem_ack) begin
                        redir_pc_d = target;
                        state_d    = DISCARD;
                    end else begin
                        pc_d = target;
                    end
                end else if (good_rsp) begin
                    pc_d = pc_plus4;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    redir_pc_d = target;
                end
                if (ack_fire) begin
                    pc_d    = redirect ? target : redir_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (!stall) begin
            if (redirect) begin
                instr_d      = NOP_INSTR;
                valid_d      = 1'b0;
                skid_valid_d = 1'b0;
            end else if (skid_valid_q) begin
                next_addr_d  = skid_addr_q;
                instr_d      = skid_instr_q;
                valid_d      = 1'b1;
                skid_valid_d = 1'b0;
            end else if (good_rsp) begin
                next_addr_d = pc_plus4;
                instr_d     = imem_rdata;
                valid_d     = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end else if (good_rsp) begin
            // Request is gated while the skid is full, so it is empty here.
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_addr_d  = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_addr_q  <= '0;
            next_addr_q  <= '0;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
            next_addr_q  <= next_addr_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage; instruction memory returns its address as data.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        jump;
    logic [25:0] jAddr;
    logic [31:0] id_next_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] next_addr;
    logic [31:0] instr;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .jump        (jump),
        .jAddr       (jAddr),
        .id_next_addr(id_next_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .next_addr   (next_addr),
        .instr       (instr),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb imem_rdata = imem_addr;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] baddr;
        logic        jmp;
        logic [25:0] jaddr;
        logic [31:0] idna;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_na;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(logic st, logic br, logic [31:0] ba, logic jm, logic [25:0] ja,
                                logic [31:0] idna, logic ack, logic req, logic [31:0] addr,
                                logic [31:0] na, logic [31:0] ins, logic vld);
        vec_t v;
        v.stall = st; v.br = br; v.baddr = ba; v.jmp = jm; v.jaddr = ja; v.idna = idna;
        v.ack = ack; v.e_req = req; v.e_addr = addr; v.e_na = na; v.e_instr = ins; v.e_valid = vld;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        stall        = v.stall;
        branch_taken = v.br;
        branch_addr  = v.baddr;
        jump         = v.jmp;
        jAddr        = v.jaddr;
        id_next_addr = v.idna;
        imem_ack     = v.ack;
        #1;
        chk($sformatf("v%0d imem_req", idx), 32'(imem_req), 32'(v.e_req));
        chk($sformatf("v%0d imem_addr", idx), imem_addr, v.e_addr);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d next_addr", idx), next_addr, v.e_na);
        chk($sformatf("v%0d instr", idx), instr, v.e_instr);
        chk($sformatf("v%0d instr_valid", idx), 32'(instr_valid), 32'(v.e_valid));
    endtask

    initial begin
        //              st br baddr          jm jaddr   idna           ack req addr           na             instr          vld
        // streaming
        vecs[0]  = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h0,         32'h4,         32'h0,         1);
        vecs[1]  = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h4,         32'h8,         32'h4,         1);
        vecs[2]  = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h8,         32'hC,         32'h8,         1);
        // 3-cycle stall: one word into the skid, then request gated
        vecs[3]  = mk(1, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'hC,         32'hC,         32'h8,         1);
        vecs[4]  = mk(1, 0, 32'h0,         0, 26'h0,  32'h0,         1, 0, 32'h10,        32'hC,         32'h8,         1);
        vecs[5]  = mk(1, 0, 32'h0,         0, 26'h0,  32'h0,         1, 0, 32'h10,        32'hC,         32'h8,         1);
        vecs[6]  = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 0, 32'h10,        32'h10,        32'hC,         1);
        vecs[7]  = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h10,        32'h14,        32'h10,        1);
        // branch with same-cycle ack
        vecs[8]  = mk(0, 1, 32'h100,       0, 26'h0,  32'h0,         1, 1, 32'h14,        32'h14,        32'h0,         0);
        vecs[9]  = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h100,       32'h104,       32'h100,       1);
        // jump wins over branch
        vecs[10] = mk(0, 1, 32'h300,       1, 26'h40, 32'h4000_0010, 1, 1, 32'h104,       32'h104,       32'h0,         0);
        vecs[11] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h4000_0100, 32'h4000_0104, 32'h4000_0100, 1);
        // redirect under stall is ignored
        vecs[12] = mk(1, 1, 32'h500,       0, 26'h0,  32'h0,         1, 1, 32'h4000_0104, 32'h4000_0104, 32'h4000_0100, 1);
        vecs[13] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 0, 32'h4000_0108, 32'h4000_0108, 32'h4000_0104, 1);
        vecs[14] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h4000_0108, 32'h4000_010C, 32'h4000_0108, 1);
        // redirect with skid full and no request pending kills the skid word
        vecs[15] = mk(1, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h4000_010C, 32'h4000_010C, 32'h4000_0108, 1);
        vecs[16] = mk(0, 1, 32'h600,       0, 26'h0,  32'h0,         1, 0, 32'h4000_0110, 32'h4000_010C, 32'h0,         0);
        vecs[17] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h600,       32'h604,       32'h600,       1);
        // redirect to 0x200 with ack delayed 3 cycles
        vecs[18] = mk(0, 1, 32'h200,       0, 26'h0,  32'h0,         0, 1, 32'h604,       32'h604,       32'h0,         0);
        vecs[19] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         0, 1, 32'h604,       32'h604,       32'h0,         0);
        vecs[20] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         0, 1, 32'h604,       32'h604,       32'h0,         0);
        vecs[21] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h604,       32'h604,       32'h0,         0);
        vecs[22] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h200,       32'h204,       32'h200,       1);
        // ack withheld without redirect: bubbles, pc held
        vecs[23] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         0, 1, 32'h204,       32'h204,       32'h0,         0);
        vecs[24] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h204,       32'h208,       32'h204,       1);
        // 32-bit PC wrap
        vecs[25] = mk(0, 1, 32'hFFFF_FFFC, 0, 26'h0,  32'h0,         1, 1, 32'h208,       32'h208,       32'h0,         0);
        vecs[26] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 1);
        vecs[27] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h0,         32'h4,         32'h0,         1);
        // enter DISCARD for the reset test below
        vecs[28] = mk(0, 0, 32'h0,         0, 26'h0,  32'h0,         1, 1, 32'h4,         32'h8,         32'h4,         1);
        vecs[29] = mk(0, 1, 32'h800,       0, 26'h0,  32'h0,         0, 1, 32'h8,         32'h8,         32'h0,         0);

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        jump = 1'b0; jAddr = '0; id_next_addr = '0; imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_req", 32'(imem_req), 32'h0);
        chk("reset next_addr", next_addr, 32'h0);
        chk("reset instr", instr, 32'h0);
        chk("reset instr_valid", 32'(instr_valid), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i], i);
        end

        // reset while in DISCARD with stall held
        stall = 1'b1; branch_taken = 1'b0; imem_ack = 1'b0; rst = 1'b1;
        #1;
        chk("rst-discard imem_req during rst", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        chk("rst-discard next_addr", next_addr, 32'h0);
        chk("rst-discard instr", instr, 32'h0);
        chk("rst-discard instr_valid", 32'(instr_valid), 32'h0);
        rst = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        #1;
        chk("post-rst imem_req", 32'(imem_req), 32'h1);
        chk("post-rst imem_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("post-rst next_addr", next_addr, 32'h4);
        chk("post-rst instr", instr, 32'h0);
        chk("post-rst instr_valid", 32'(instr_valid), 32'h1);
        #1;
        chk("post-rst 2nd imem_addr", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
